// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor / BTB.
//   - ctr_e       : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - btbEntry_t  : per-entry control state (valid, counter, jump flag)
//   - idxWidth()  : index width for a given entry count
//   - tagWidth()  : tag width for a given address width and entry count
// Tag and target widths depend on the instantiating module's XLEN. They
// therefore live in parallel arrays beside btbEntry_t, indexed identically.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
    logic       jump;
  } btbEntry_t;

  function automatic int idxWidth(input int entries);
    return $clog2(entries);
  endfunction

  // Word-aligned PCs: bits [1:0] are dropped, then the index, then the tag.
  function automatic int tagWidth(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating counter step.
// Ports:
//   ctrIn  : current counter value
//   inc    : increment request (saturates at ST)
//   dec    : decrement request (saturates at SNT)
//   ctrOut : next counter value (unchanged when neither or both are requested)
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctrIn,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctrOut
);

  always_comb begin
    ctrOut = ctrIn;
    if (inc && !dec) begin
      if (ctrIn != ST) ctrOut = ctrIn + 2'd1;
    end else if (dec && !inc) begin
      if (ctrIn != SNT) ctrOut = ctrIn - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch side looks up pc_f combinationally; execute side trains the table
// with resolved branches and flags mispredictions.
// Optional feature: define BP_STATS_EN to add saturating 32-bit statistics
// counters stat_updates / stat_mispredicts.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   pc_f                  : fetch PC to look up
//   pred_taken_f          : predicted taken for pc_f
//   pred_target_f         : predicted next PC (target or pc_f+4)
//   upd_valid_e           : resolved branch/jump present in execute
//   upd_pc_e/upd_target_e : resolved instruction PC and actual target
//   upd_taken_e           : actual outcome
//   upd_jump_e            : unconditional jump flag
//   upd_pred_taken_e      : prediction made at fetch
//   upd_pred_target_e     : predicted target made at fetch
//   mispredict_e          : prediction was wrong (flush decode/execute)
//   recover_pc_e          : correct next PC
//   stat_updates          : (BP_STATS_EN) count of upd_valid_e cycles
//   stat_mispredicts      : (BP_STATS_EN) count of mispredict_e cycles
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_valid_e,
  input  logic [XLEN-1:0] upd_pc_e,
  input  logic [XLEN-1:0] upd_target_e,
  input  logic            upd_taken_e,
  input  logic            upd_jump_e,
  input  logic            upd_pred_taken_e,
  input  logic [XLEN-1:0] upd_pred_target_e,
  output logic            mispredict_e,
  output logic [XLEN-1:0] recover_pc_e
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = idxWidth(ENTRIES);
  localparam int TAG_W = tagWidth(XLEN, ENTRIES);

  btbEntry_t        entryCtl  [ENTRIES];
  logic [TAG_W-1:0] tagMem    [ENTRIES];
  logic [XLEN-1:0]  targetMem [ENTRIES];

  // Lookup stage (fetch)
  logic [IDX_W-1:0] lkIdx;
  logic [TAG_W-1:0] lkTag;
  logic             lkHit;
  logic [XLEN-1:0]  pcPlus4F;

  assign lkIdx    = pc_f[IDX_W+1:2];
  assign lkTag    = pc_f[XLEN-1:IDX_W+2];
  assign lkHit    = entryCtl[lkIdx].valid && (tagMem[lkIdx] == lkTag);
  assign pcPlus4F = pc_f + XLEN'(4);

  // Gate on rst so the fetch side goes not-taken the instant reset asserts,
  // independent of the table clear.
  assign pred_taken_f  = !rst && lkHit && (entryCtl[lkIdx].ctr[1] || entryCtl[lkIdx].jump);
  assign pred_target_f = pred_taken_f ? targetMem[lkIdx] : pcPlus4F;

  // Resolve stage (execute)
  assign mispredict_e = upd_valid_e &&
                        ((upd_taken_e != upd_pred_taken_e) ||
                         (upd_taken_e && (upd_target_e != upd_pred_target_e)));
  assign recover_pc_e = upd_taken_e ? upd_target_e : (upd_pc_e + XLEN'(4));

  // Training
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic             wrEn;
  logic             ctlWrite;
  logic [1:0]       ctrStep;
  logic [1:0]       nextCtr;

  assign updIdx   = upd_pc_e[IDX_W+1:2];
  assign updTag   = upd_pc_e[XLEN-1:IDX_W+2];
  assign updHit   = entryCtl[updIdx].valid && (tagMem[updIdx] == updTag);
  assign wrEn     = upd_valid_e && !rst;
  // Taken always writes (allocate or refresh); not-taken only touches a hit.
  assign ctlWrite = wrEn && (upd_taken_e || updHit);

  bp_sat_counter uSatCtr (
    .ctrIn  (entryCtl[updIdx].ctr),
    .inc    (upd_taken_e),
    .dec    (!upd_taken_e),
    .ctrOut (ctrStep)
  );

  // Jumps pin the counter strongly taken; a fresh allocation starts at CTR_INIT.
  assign nextCtr = upd_jump_e ? ST : (updHit ? ctrStep : CTR_INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entryCtl[i].valid <= 1'b0;
        entryCtl[i].ctr   <= WNT;
        entryCtl[i].jump  <= 1'b0;
      end
    end else if (ctlWrite) begin
      entryCtl[updIdx].valid <= 1'b1;
      entryCtl[updIdx].ctr   <= nextCtr;
      if (upd_taken_e) entryCtl[updIdx].jump <= upd_jump_e;
    end
  end

  // Tag/target payload needs no reset: it is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (wrEn && upd_taken_e) begin
      tagMem[updIdx]    <= updTag;
      targetMem[updIdx] <= upd_target_e;
    end
  end

`ifdef BP_STATS_EN
  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid_e)  stat_updates     <= satInc32(stat_updates);
      if (mispredict_e) stat_mispredicts <= satInc32(stat_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (XLEN=32, ENTRIES=16, CTR_INIT=10).
// Index = pc[5:2], tag = pc[31:6]; 0x100, 0x140 and 0x180 share index 0.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid_e;
  logic [31:0] upd_pc_e;
  logic [31:0] upd_target_e;
  logic        upd_taken_e;
  logic        upd_jump_e;
  logic        upd_pred_taken_e;
  logic [31:0] upd_pred_target_e;
  logic        mispredict_e;
  logic [31:0] recover_pc_e;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int nChecks = 0;
  int nErrors = 0;

  branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .CTR_INIT(2'b10)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_f              (pc_f),
    .pred_taken_f      (pred_taken_f),
    .pred_target_f     (pred_target_f),
    .upd_valid_e       (upd_valid_e),
    .upd_pc_e          (upd_pc_e),
    .upd_target_e      (upd_target_e),
    .upd_taken_e       (upd_taken_e),
    .upd_jump_e        (upd_jump_e),
    .upd_pred_taken_e  (upd_pred_taken_e),
    .upd_pred_target_e (upd_pred_target_e),
    .mispredict_e      (mispredict_e),
    .recover_pc_e      (recover_pc_e)
`ifdef BP_STATS_EN
    ,
    .stat_updates      (stat_updates),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleUpd();
    upd_valid_e       = 1'b0;
    upd_pc_e          = '0;
    upd_target_e      = '0;
    upd_taken_e       = 1'b0;
    upd_jump_e        = 1'b0;
    upd_pred_taken_e  = 1'b0;
    upd_pred_target_e = '0;
  endtask

  task automatic drvUpd(input logic [31:0] pc, input logic taken, input logic jump,
                        input logic [31:0] tgt, input logic pTaken, input logic [31:0] pTgt);
    upd_valid_e       = 1'b1;
    upd_pc_e          = pc;
    upd_taken_e       = taken;
    upd_jump_e        = jump;
    upd_target_e      = tgt;
    upd_pred_taken_e  = pTaken;
    upd_pred_target_e = pTgt;
  endtask

  // One clocked update, then the update port goes idle again.
  task automatic update(input logic [31:0] pc, input logic taken, input logic jump,
                        input logic [31:0] tgt);
    drvUpd(pc, taken, jump, tgt, 1'b0, 32'h0);
    tick();
    idleUpd();
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic expTaken, input logic [31:0] expTgt);
    pc_f = pc;
    #1;
    checkEq({tag, "_taken"}, {31'd0, pred_taken_f}, {31'd0, expTaken});
    checkEq({tag, "_target"}, pred_target_f, expTgt);
  endtask

  initial begin
    logic expNt [5];
    expNt[0] = 1'b1; expNt[1] = 1'b0; expNt[2] = 1'b0; expNt[3] = 1'b0; expNt[4] = 1'b0;

    rst = 1'b1;
    pc_f = 32'h100;
    idleUpd();
    tick();
    tick();

    // Reset behaviour
    lookup("rst", 32'h100, 1'b0, 32'h104);
    drvUpd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h104);
    #1;
    checkEq("rst_misp", {31'd0, mispredict_e}, 32'd1);
    tick();
    idleUpd();
    rst = 1'b0;
    lookup("rst_upd_ignored", 32'h100, 1'b0, 32'h104);
`ifdef BP_STATS_EN
    checkEq("stat_upd_rst", stat_updates, 32'd0);
    checkEq("stat_misp_rst", stat_mispredicts, 32'd0);
`endif

    // Allocate: mispredict, same-cycle lookup sees the old entry
    drvUpd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h104);
    pc_f = 32'h100;
    #1;
    checkEq("alloc_misp", {31'd0, mispredict_e}, 32'd1);
    checkEq("alloc_recover", recover_pc_e, 32'h200);
    checkEq("same_cycle_taken", {31'd0, pred_taken_f}, 32'd0);
    checkEq("same_cycle_target", pred_target_f, 32'h104);
    tick();
    idleUpd();
    lookup("after_alloc", 32'h100, 1'b1, 32'h200);
`ifdef BP_STATS_EN
    checkEq("stat_upd_1", stat_updates, 32'd1);
    checkEq("stat_misp_1", stat_mispredicts, 32'd1);
`endif

    // Mispredict detection variants
    drvUpd(32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    checkEq("correct_pred_misp", {31'd0, mispredict_e}, 32'd0);
    upd_pred_target_e = 32'h300;
    #1;
    checkEq("wrong_target_misp", {31'd0, mispredict_e}, 32'd1);
    drvUpd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    #1;
    checkEq("nt_misp", {31'd0, mispredict_e}, 32'd1);
    checkEq("nt_recover", recover_pc_e, 32'h104);
    idleUpd();
    #1;
    checkEq("idle_misp", {31'd0, mispredict_e}, 32'd0);

    // Conflict replacement at index 0
    update(32'h140, 1'b1, 1'b0, 32'h400);
    lookup("replaced_old", 32'h100, 1'b0, 32'h104);
    lookup("replaced_new", 32'h140, 1'b1, 32'h400);

    // Counter saturation at 0x100
    for (int i = 0; i < 4; i++) update(32'h100, 1'b1, 1'b0, 32'h200);
    lookup("sat_hi", 32'h100, 1'b1, 32'h200);
    for (int i = 0; i < 5; i++) begin
      update(32'h100, 1'b0, 1'b0, 32'h0);
      lookup($sformatf("nt%0d", i + 1), 32'h100, expNt[i], expNt[i] ? 32'h200 : 32'h104);
    end
    update(32'h100, 1'b1, 1'b0, 32'h200);
    lookup("sat_lo_01", 32'h100, 1'b0, 32'h104);
    update(32'h100, 1'b1, 1'b0, 32'h200);
    lookup("sat_lo_10", 32'h100, 1'b1, 32'h200);

    // Not-taken miss leaves the table alone; pc[1:0] ignored
    update(32'h180, 1'b0, 1'b0, 32'h0);
    lookup("nt_miss_keep", 32'h100, 1'b1, 32'h200);
    lookup("low_bits", 32'h102, 1'b1, 32'h200);

    // Jump entries at 0x104 (index 1)
    update(32'h104, 1'b1, 1'b1, 32'h800);
    for (int i = 0; i < 3; i++) update(32'h104, 1'b0, 1'b0, 32'h0);
    lookup("jump_flag", 32'h104, 1'b1, 32'h800);
    update(32'h104, 1'b0, 1'b1, 32'h0);
    update(32'h104, 1'b1, 1'b0, 32'h900);
    lookup("jump_forces_st", 32'h104, 1'b1, 32'h900);
    update(32'h104, 1'b0, 1'b0, 32'h0);
    lookup("after_jump_nt1", 32'h104, 1'b1, 32'h900);
    update(32'h104, 1'b0, 1'b0, 32'h0);
    lookup("after_jump_nt2", 32'h104, 1'b0, 32'h108);

    // Address wrap
    lookup("wrap_fetch", 32'hFFFF_FFFC, 1'b0, 32'h0);
    drvUpd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    #1;
    checkEq("wrap_recover", recover_pc_e, 32'h0);
    checkEq("wrap_misp", {31'd0, mispredict_e}, 32'd1);
    idleUpd();

    // Mid-run asynchronous reset, no clock edge in between
    tick();
    pc_f = 32'h100;
    #1;
    checkEq("pre_rst_taken", {31'd0, pred_taken_f}, 32'd1);
    rst = 1'b1;
    #1;
    checkEq("async_rst_taken", {31'd0, pred_taken_f}, 32'd0);
    checkEq("async_rst_target", pred_target_f, 32'h104);
    tick();
    rst = 1'b0;
    lookup("post_rst_cleared", 32'h100, 1'b0, 32'h104);
    lookup("post_rst_jump_cleared", 32'h104, 1'b0, 32'h108);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
